axi_uart_fifo_bridge: RTL
=========================

// Module: axi_uart_fifo_bridge
// PURPOSE
//  AXI4-lite slave bridging the CPU bus to a byte-stream UART core (serializer/deserializer).
//  Generalises the 3-word register adapter: parametrised TX/RX FIFOs, status/control regs, IRQ,
//  full AW/W decoupling, BRESP/RRESP error reporting.
//  Sits on the SoC AXI-lite interconnect at BASE_ADDR; UART core attaches on the stream side.
// PARAMETERS
//  BASE_ADDR  32'h00018000  base of 16-byte register window
//  TX_DEPTH   16            TX FIFO entries; power of 2, >=2
//  RX_DEPTH   16            RX FIFO entries; power of 2, >=2
//  DIV_RESET  32'd1         reset value of DIV register
// PORTS
//  clk             in   1   clock
//  resetn          in   1   async active-low reset
//  mem_axi_aw*     in/out       awvalid/awready/awaddr[31:0]/awprot[2:0] (prot ignored)
//  mem_axi_w*      in/out       wvalid/wready/wdata[31:0]/wstrb[3:0]
//  mem_axi_bvalid  out  1 / mem_axi_bready in 1 / mem_axi_bresp out 2 (00 OKAY, 10 SLVERR)
//  mem_axi_ar*     in/out       arvalid/arready/araddr[31:0]/arprot[2:0] (prot ignored)
//  mem_axi_rvalid  out  1 / mem_axi_rready in 1 / mem_axi_rdata out 32 / mem_axi_rresp out 2
//  cfg_div         out  32  baud divider to UART core (= DIV register)
//  tx_data/tx_valid out 8/1; tx_ready in 1   TX stream; pop on valid&ready
//  rx_data/rx_valid in  8/1                  RX stream; no backpressure
//  irq             out  1   level interrupt
// BEHAVIOUR
//  Map (offset, word-aligned): 0x0 DIV RW; 0x4 DATA (W push TX byte wdata[7:0], R pop RX);
//   0x8 STATUS: [7:0] tx_count,[15:8] rx_count,[16] tx_full,[17] rx_empty,[18] rx_overrun (W1C);
//   0xC CTRL RW: [0] rx_irq_en,[1] tx_irq_en; [8] tx_flush,[9] rx_flush write-1 pulses, read 0.
//  Address outside BASE_ADDR..+0xF: no side effect, resp SLVERR, rdata 0.
//  DIV honours wstrb per byte; DATA push requires wstrb[0] (else OKAY, no push).
//  Reset: awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=0; rdata=0; DIV=DIV_RESET;
//   CTRL=0; FIFOs empty; overrun=0; tx_valid=0; irq=0. Reset mid-transaction aborts it; no response.
//  Write FSM W_IDLE->W_EXEC->W_RESP:
//   W_IDLE: AW and W accepted independently (awready/wready drop once its half is latched).
//   Both latched -> W_EXEC. DATA write with TX full stalls in W_EXEC until a slot frees.
//   W_EXEC performs write (1 cycle if no stall) -> W_RESP: bvalid=1 until bready; then W_IDLE,
//   awready=wready=1 the following cycle. Min latency: last of AW/W handshake -> bvalid +2 clk.
//  Read FSM R_IDLE->R_RESP: AR handshake in R_IDLE; next cycle rvalid=1 with data, arready=0;
//   held stable until rready; then R_IDLE. DATA read pops RX at the AR-accept edge;
//   RX empty -> rdata=32'hFFFF_FFFF, no pop, OKAY; else rdata={24'h0,byte}.
//  Read and write FSMs independent; may complete in the same cycle.
//  FIFOs: count width $clog2(DEPTH)+1, reported zero-extended/saturated to 8 bits; pointers wrap
//   mod DEPTH. Push+pop same cycle: count unchanged (also when full on TX pop side, when empty on
//   RX if push). RX push when full: byte dropped, overrun set; overrun set wins over same-cycle W1C.
//  Flush: clears FIFO pointers/counts next edge; flush coincident with push -> FIFO ends empty.
//  tx_valid = !tx_empty, tx_data = head entry (registered FIFO storage, no comb path from AXI).
//  irq = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty) | rx_overrun; registered, 1 clk lag.
// TESTING
//  Reset, read STATUS -> 0x0002_0000; read DIV -> DIV_RESET; irq=0.
//  Write DATA 0x41,0x42 with tx_ready=0 -> tx_count=2, tx_data=0x41; tx_ready=1 2 clk -> 0x41,0x42 out.
//  Fill TX to TX_DEPTH, 17th write -> bvalid withheld until tx_ready pops 1 byte, then OKAY.
//  Inject RX_DEPTH+1 bytes -> rx_count=16, overrun=1, irq=1; read DATA 16x in order, 17th -> FFFF_FFFF.
//  AW 3 clk before W, and W before AW, with bready low 4 clk -> single write, bvalid held stable.
//  Read 0x00018010 / write 0x00017FFC -> SLVERR, rdata 0, no state change.

Source files
------------

// File: rtl/axi_uart_fifo_bridge.sv
// AXI4-lite slave exposing a UART byte-stream core through DIV/DATA/STATUS/CTRL registers,
// with TX/RX FIFOs, overrun tracking and a level interrupt.
module axi_uart_fifo_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_8000,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16,
  parameter logic [31:0] DIV_RESET = 32'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  output logic [1:0]  mem_axi_bresp,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic [1:0]  mem_axi_rresp,
  output logic [31:0] cfg_div,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        irq
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0]   TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0]   RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
  localparam logic [TX_AW-1:0] TX_PTR_ONE  = TX_AW'(1);
  localparam logic [RX_AW-1:0] RX_PTR_ONE  = RX_AW'(1);
  localparam logic [TX_AW:0]   TX_CNT_ONE  = (TX_AW+1)'(1);
  localparam logic [RX_AW:0]   RX_CNT_ONE  = (RX_AW+1)'(1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] OFF_DIV     = 2'd0;
  localparam logic [1:0] OFF_DATA    = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_CTRL    = 2'd3;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  function automatic logic [7:0] sat8(input logic [31:0] v);
    if (v > 32'd255) sat8 = 8'hFF;
    else             sat8 = v[7:0];
  endfunction

  w_state_t w_state_r, w_state_s;
  r_state_t r_state_r, r_state_s;
  logic        aw_done_r, w_done_r;
  logic [31:0] awaddr_r, wdata_r;
  logic [3:0]  wstrb_r;
  logic [1:0]  bresp_r, rresp_r;
  logic [31:0] rdata_r, div_r, rd_mux_s, status_s;
  logic [1:0]  ctrl_r;
  logic        overrun_r, irq_r;

  logic [7:0]       tx_mem_r [TX_DEPTH];
  logic [TX_AW-1:0] tx_wp_r, tx_rp_r;
  logic [TX_AW:0]   tx_cnt_r;
  logic [7:0]       rx_mem_r [RX_DEPTH];
  logic [RX_AW-1:0] rx_wp_r, rx_rp_r;
  logic [RX_AW:0]   rx_cnt_r;

  logic aw_hs_s, w_hs_s, ar_hs_s, w_hit_s, r_hit_s, stall_s, do_write_s;
  logic wr_div_s, wr_ctrl_s, wr_status_s, tx_push_s, tx_pop_s, tx_flush_s, rx_flush_s;
  logic rx_push_s, rx_drop_s, rx_pop_s, tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
  logic [1:0] w_off_s, r_off_s;
  logic unused_s;

  assign unused_s = ^{mem_axi_awprot, mem_axi_arprot, awaddr_r[1:0], mem_axi_araddr[1:0]};

  assign mem_axi_awready = (w_state_r == W_IDLE) && !aw_done_r;
  assign mem_axi_wready  = (w_state_r == W_IDLE) && !w_done_r;
  assign mem_axi_bvalid  = (w_state_r == W_RESP);
  assign mem_axi_bresp   = bresp_r;
  assign mem_axi_arready = (r_state_r == R_IDLE);
  assign mem_axi_rvalid  = (r_state_r == R_RESP);
  assign mem_axi_rdata   = rdata_r;
  assign mem_axi_rresp   = rresp_r;
  assign cfg_div         = div_r;
  assign irq             = irq_r;

  assign aw_hs_s = mem_axi_awvalid && mem_axi_awready;
  assign w_hs_s  = mem_axi_wvalid && mem_axi_wready;
  assign ar_hs_s = mem_axi_arvalid && mem_axi_arready;

  assign w_hit_s = (awaddr_r[31:4] == BASE_ADDR[31:4]);
  assign w_off_s = awaddr_r[3:2];
  assign r_hit_s = (mem_axi_araddr[31:4] == BASE_ADDR[31:4]);
  assign r_off_s = mem_axi_araddr[3:2];

  assign tx_empty_s = (tx_cnt_r == {(TX_AW+1){1'b0}});
  assign tx_full_s  = (tx_cnt_r == TX_FULL_CNT);
  assign rx_empty_s = (rx_cnt_r == {(RX_AW+1){1'b0}});
  assign rx_full_s  = (rx_cnt_r == RX_FULL_CNT);

  // A DATA push into a full TX FIFO holds the write in W_EXEC until the stream side drains a byte.
  assign stall_s     = (w_state_r == W_EXEC) && w_hit_s && (w_off_s == OFF_DATA) && wstrb_r[0] && tx_full_s;
  assign do_write_s  = (w_state_r == W_EXEC) && !stall_s;
  assign wr_div_s    = do_write_s && w_hit_s && (w_off_s == OFF_DIV);
  assign wr_ctrl_s   = do_write_s && w_hit_s && (w_off_s == OFF_CTRL);
  assign wr_status_s = do_write_s && w_hit_s && (w_off_s == OFF_STATUS);
  assign tx_push_s   = do_write_s && w_hit_s && (w_off_s == OFF_DATA) && wstrb_r[0];
  assign tx_flush_s  = wr_ctrl_s && wdata_r[8];
  assign rx_flush_s  = wr_ctrl_s && wdata_r[9];
  assign tx_pop_s    = !tx_empty_s && tx_ready;
  assign rx_push_s   = rx_valid && !rx_full_s;
  assign rx_drop_s   = rx_valid && rx_full_s;
  assign rx_pop_s    = ar_hs_s && r_hit_s && (r_off_s == OFF_DATA) && !rx_empty_s;

  assign tx_valid = !tx_empty_s;
  assign tx_data  = tx_mem_r[tx_rp_r];

  assign status_s = {13'h0, overrun_r, rx_empty_s, tx_full_s, sat8(32'(rx_cnt_r)), sat8(32'(tx_cnt_r))};

  // Write FSM next state.
  always_comb begin
    w_state_s = w_state_r;
    case (w_state_r)
      W_IDLE: begin
        if ((aw_hs_s || aw_done_r) && (w_hs_s || w_done_r)) w_state_s = W_EXEC;
        else                                                 w_state_s = W_IDLE;
      end
      W_EXEC: begin
        if (!stall_s) w_state_s = W_RESP;
        else          w_state_s = W_EXEC;
      end
      W_RESP: begin
        if (mem_axi_bready) w_state_s = W_IDLE;
        else                w_state_s = W_RESP;
      end
      default: w_state_s = W_IDLE;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    r_state_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (mem_axi_arvalid) r_state_s = R_RESP;
        else                 r_state_s = R_IDLE;
      end
      R_RESP: begin
        if (mem_axi_rready) r_state_s = R_IDLE;
        else                r_state_s = R_RESP;
      end
      default: r_state_s = R_IDLE;
    endcase
  end

  // Read data mux; misses return zero.
  always_comb begin
    rd_mux_s = 32'h0;
    if (!r_hit_s) begin
      rd_mux_s = 32'h0;
    end else begin
      case (r_off_s)
        OFF_DIV:    rd_mux_s = div_r;
        OFF_DATA:   rd_mux_s = rx_empty_s ? 32'hFFFF_FFFF : {24'h0, rx_mem_r[rx_rp_r]};
        OFF_STATUS: rd_mux_s = status_s;
        OFF_CTRL:   rd_mux_s = {30'h0, ctrl_r};
        default:    rd_mux_s = 32'h0;
      endcase
    end
  end

  // AXI channel state, latched address/data halves and responses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_r <= W_IDLE;
      r_state_r <= R_IDLE;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      awaddr_r  <= 32'h0;
      wdata_r   <= 32'h0;
      wstrb_r   <= 4'h0;
      bresp_r   <= RESP_OKAY;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= 32'h0;
    end else begin
      w_state_r <= w_state_s;
      r_state_r <= r_state_s;
      if (w_state_r != W_IDLE) begin
        aw_done_r <= 1'b0;
        w_done_r  <= 1'b0;
      end else begin
        if (aw_hs_s) begin
          awaddr_r  <= mem_axi_awaddr;
          aw_done_r <= 1'b1;
        end
        if (w_hs_s) begin
          wdata_r  <= mem_axi_wdata;
          wstrb_r  <= mem_axi_wstrb;
          w_done_r <= 1'b1;
        end
      end
      if (do_write_s) bresp_r <= w_hit_s ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs_s) begin
        rdata_r <= rd_mux_s;
        rresp_r <= r_hit_s ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Control registers, overrun flag and interrupt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_r     <= DIV_RESET;
      ctrl_r    <= 2'b00;
      overrun_r <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_div_s && wstrb_r[i]) div_r[8*i +: 8] <= wdata_r[8*i +: 8];
      end
      if (wr_ctrl_s) ctrl_r <= wdata_r[1:0];
      if (rx_drop_s)                    overrun_r <= 1'b1;
      else if (wr_status_s && wdata_r[18]) overrun_r <= 1'b0;
      irq_r <= (ctrl_r[0] && !rx_empty_s) || (ctrl_r[1] && tx_empty_s) || overrun_r;
    end
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_wp_r  <= {TX_AW{1'b0}};
      tx_rp_r  <= {TX_AW{1'b0}};
      tx_cnt_r <= {(TX_AW+1){1'b0}};
    end else if (tx_flush_s) begin
      tx_wp_r  <= {TX_AW{1'b0}};
      tx_rp_r  <= {TX_AW{1'b0}};
      tx_cnt_r <= {(TX_AW+1){1'b0}};
    end else begin
      if (tx_push_s) tx_wp_r <= tx_wp_r + TX_PTR_ONE;
      if (tx_pop_s)  tx_rp_r <= tx_rp_r + TX_PTR_ONE;
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_cnt_r <= tx_cnt_r + TX_CNT_ONE;
        2'b01:   tx_cnt_r <= tx_cnt_r - TX_CNT_ONE;
        default: tx_cnt_r <= tx_cnt_r;
      endcase
    end
  end

  // RX FIFO pointers and occupancy; a flush overrides a same-cycle push.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_wp_r  <= {RX_AW{1'b0}};
      rx_rp_r  <= {RX_AW{1'b0}};
      rx_cnt_r <= {(RX_AW+1){1'b0}};
    end else if (rx_flush_s) begin
      rx_wp_r  <= {RX_AW{1'b0}};
      rx_rp_r  <= {RX_AW{1'b0}};
      rx_cnt_r <= {(RX_AW+1){1'b0}};
    end else begin
      if (rx_push_s) rx_wp_r <= rx_wp_r + RX_PTR_ONE;
      if (rx_pop_s)  rx_rp_r <= rx_rp_r + RX_PTR_ONE;
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_cnt_r <= rx_cnt_r + RX_CNT_ONE;
        2'b01:   rx_cnt_r <= rx_cnt_r - RX_CNT_ONE;
        default: rx_cnt_r <= rx_cnt_r;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_r[tx_wp_r] <= wdata_r[7:0];
    if (rx_push_s) rx_mem_r[rx_wp_r] <= rx_data;
  end

endmodule
